ber_monitor: RTL and testbench
==============================

BER_MONITOR -- requirements
Module: ber_monitor

Interface
REQ-001 SHALL have parameter ERR_W, default 7, width of the per-word error count input.
REQ-002 SHALL have parameter TOT_W, default 32, width of the accumulated error and errored-word counters.
REQ-003 SHALL have port clk, input, 1, the recovered parallel-word clock.
REQ-004 SHALL have port reset, input, 1, a synchronous, active-high reset sampled on clk.
REQ-005 SHALL have port aligned, input, 1, word-alignment lock from the upstream extractor.
REQ-006 SHALL have port err_cnt, input, ERR_W, the bit-error count of the current 64-bit word from the PRBS7 checker.
REQ-007 SHALL have port start, input, 1, a single-cycle pulse that arms a measurement.
REQ-008 SHALL have port abort, input, 1, a single-cycle pulse that cancels a measurement.
REQ-009 SHALL have port window_log2, input, 6, giving a window of 2^window_log2 words; valid range 4..40.
REQ-010 SHALL have port busy, output, 1, high in WAIT_LOCK and MEASURE.
REQ-011 SHALL have port done, output, 1, a one-cycle pulse on window completion.
REQ-012 SHALL have port result_valid, output, 1, high in DONE.
REQ-013 SHALL have port word_cnt, output, 41, the words counted in the current window.
REQ-014 SHALL have port err_total, output, TOT_W, the sum of err_cnt over counted words.
REQ-015 SHALL have port err_words, output, TOT_W, the number of counted words with err_cnt != 0.
REQ-016 SHALL have port err_max, output, ERR_W, the largest err_cnt seen in the window.
REQ-017 SHALL have port lock_loss, output, 8, the number of aligned 1->0 transitions seen in MEASURE.

Function
REQ-018 SHALL have FSM states IDLE, WAIT_LOCK, MEASURE and DONE.
REQ-019 SHALL transition IDLE or DONE to WAIT_LOCK on start; start is ignored in WAIT_LOCK and MEASURE.
REQ-020 SHALL transition WAIT_LOCK to MEASURE on the first cycle with aligned=1, and clear all result counters in that same cycle.
REQ-021 SHALL, in MEASURE with aligned=1, increment word_cnt by 1 and add err_cnt to err_total each cycle.
REQ-022 SHALL, in MEASURE with aligned=1 and err_cnt != 0, increment err_words.
REQ-023 SHALL, in MEASURE, update err_max to err_cnt whenever err_cnt > err_max.
REQ-024 SHALL, in MEASURE with aligned=0, not change word_cnt, err_total, err_words or err_max.
REQ-025 SHALL transition MEASURE to DONE on the cycle in which word_cnt becomes 2^window_log2, and assert done in that cycle only.
REQ-026 SHALL hold all results stable in DONE until the next start.
REQ-027 SHALL make err_total, err_words and lock_loss saturate at all-ones and never wrap.
REQ-028 SHALL, on abort in any state, go to IDLE and hold the counters; abort takes priority over start and over window completion in the same cycle.
REQ-029 SHALL clamp window_log2 < 4 to 4 and window_log2 > 40 to 40; the value is sampled on the WAIT_LOCK->MEASURE transition.
REQ-030 SHALL detect a lock-loss edge from a registered copy of aligned.
REQ-031 SHALL register all outputs, with results visible one cycle after the sampled input.

Reset
REQ-032 SHALL, on reset, put the FSM in IDLE, drive all outputs to 0 and clear the registered copy of aligned.
REQ-033 SHALL, on reset mid-measurement, discard the partial results; reset overrides start and abort.

Configuration
REQ-034 SHALL implement the BER_MON_ABORT_ON_UNLOCK_EN macro.
- Defined: in MEASURE, aligned 1->0 increments lock_loss, then moves to IDLE with the counters held.
- Undefined: counting pauses while unaligned, lock_loss increments, and the measurement resumes when aligned returns.

Verification
REQ-035 SHALL verify a clean run: window_log2=4, aligned=1, err_cnt=0, start -> done after 16 counted words; word_cnt=16, err_total=0, err_words=0.
REQ-036 SHALL verify error accumulation: window_log2=5, err_cnt=3 on words 2 and 7 and err_cnt=5 on word 20 -> err_total=11, err_words=3, err_max=5.
REQ-037 SHALL verify an unlock gap: aligned=0 for 10 cycles mid-window, window_log2=4.
- Macro undefined: done after 16 aligned words and lock_loss=1.
- Macro defined: state IDLE, lock_loss=1, done never asserts.
REQ-038 SHALL verify saturation: force err_total to 2^32-2, then err_cnt=7 -> err_total=0xFFFFFFFF, which holds on later errors.
REQ-039 SHALL verify same-cycle precedence: abort and start together in DONE -> IDLE; reset asserted in MEASURE -> all outputs 0 on the next cycle.
REQ-040 SHALL verify wait-for-lock: start with aligned=0 for 50 cycles -> busy=1 and word_cnt=0; counting starts on the first cycle with aligned=1.

Source files
------------

// File: rtl/ber_monitor.sv
// Bit-error-rate window monitor: accumulates per-word PRBS error counts over 2^N aligned words.
// Optional macro BER_MON_ABORT_ON_UNLOCK_EN: lock loss during a measurement cancels it instead of pausing.
module ber_monitor #(
  parameter int ERR_W = 7,
  parameter int TOT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             aligned,
  input  logic [ERR_W-1:0] err_cnt,
  input  logic             start,
  input  logic             abort,
  input  logic [5:0]       window_log2,
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic [40:0]      word_cnt,
  output logic [TOT_W-1:0] err_total,
  output logic [TOT_W-1:0] err_words,
  output logic [ERR_W-1:0] err_max,
  output logic [7:0]       lock_loss
);

  typedef enum logic [1:0] {IDLE, WAIT_LOCK, MEASURE, DONE} state_t;

  state_t           r_state;
  logic             r_aligned_d;
  logic [5:0]       r_win;
  logic             r_busy;
  logic             r_done;
  logic             r_result_valid;
  logic [40:0]      r_word_cnt;
  logic [TOT_W-1:0] r_err_total;
  logic [TOT_W-1:0] r_err_words;
  logic [ERR_W-1:0] r_err_max;
  logic [7:0]       r_lock_loss;

  logic [5:0]       w_win_clamped;
  logic [40:0]      w_target;
  logic [40:0]      w_word_inc;
  logic [TOT_W:0]   w_total_sum;
  logic [TOT_W-1:0] w_total_sat;
  logic [TOT_W-1:0] w_words_sat;
  logic [7:0]       w_lock_loss_sat;
  logic             w_unlock;

  assign w_win_clamped   = (window_log2 < 6'd4)  ? 6'd4  :
                           (window_log2 > 6'd40) ? 6'd40 : window_log2;
  assign w_target        = 41'd1 << r_win;
  assign w_word_inc      = r_word_cnt + 41'd1;
  // One extra bit catches the carry so the total pins at all-ones instead of wrapping.
  assign w_total_sum     = {1'b0, r_err_total} + {{(TOT_W + 1 - ERR_W){1'b0}}, err_cnt};
  assign w_total_sat     = w_total_sum[TOT_W] ? {TOT_W{1'b1}} : w_total_sum[TOT_W-1:0];
  assign w_words_sat     = (&r_err_words) ? r_err_words : r_err_words + 1'b1;
  assign w_lock_loss_sat = (&r_lock_loss) ? r_lock_loss : r_lock_loss + 8'd1;
  assign w_unlock        = r_aligned_d & ~aligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_aligned_d    <= 1'b0;
      r_win          <= 6'd4;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result_valid <= 1'b0;
      r_word_cnt     <= '0;
      r_err_total    <= '0;
      r_err_words    <= '0;
      r_err_max      <= '0;
      r_lock_loss    <= '0;
    end else begin
      r_aligned_d <= aligned;
      r_done      <= 1'b0;
      if (abort) begin
        r_state        <= IDLE;
        r_busy         <= 1'b0;
        r_result_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE, DONE: begin
            if (start) begin
              r_state        <= WAIT_LOCK;
              r_busy         <= 1'b1;
              r_result_valid <= 1'b0;
              r_word_cnt     <= '0;
              r_err_total    <= '0;
              r_err_words    <= '0;
              r_err_max      <= '0;
              r_lock_loss    <= '0;
            end
          end
          WAIT_LOCK: begin
            // The locking cycle only opens the window; its word is not counted.
            if (aligned) begin
              r_state     <= MEASURE;
              r_win       <= w_win_clamped;
              r_word_cnt  <= '0;
              r_err_total <= '0;
              r_err_words <= '0;
              r_err_max   <= '0;
              r_lock_loss <= '0;
            end
          end
          MEASURE: begin
            if (w_unlock) begin
              r_lock_loss <= w_lock_loss_sat;
`ifdef BER_MON_ABORT_ON_UNLOCK_EN
              r_state     <= IDLE;
              r_busy      <= 1'b0;
`endif
            end
            if (aligned) begin
              r_word_cnt  <= w_word_inc;
              r_err_total <= w_total_sat;
              if (err_cnt != '0) r_err_words <= w_words_sat;
              if (err_cnt > r_err_max) r_err_max <= err_cnt;
              if (w_word_inc == w_target) begin
                r_state        <= DONE;
                r_done         <= 1'b1;
                r_busy         <= 1'b0;
                r_result_valid <= 1'b1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign result_valid = r_result_valid;
  assign word_cnt     = r_word_cnt;
  assign err_total    = r_err_total;
  assign err_words    = r_err_words;
  assign err_max      = r_err_max;
  assign lock_loss    = r_lock_loss;

endmodule

// File: tb/tb_ber_monitor.sv
// Directed bench for ber_monitor; a second instance with an 8-bit accumulator
// shares all inputs so saturation can be reached in a few hundred cycles.
module tb_ber_monitor;

  logic        clk = 1'b0;
  logic        reset, aligned, start, abort;
  logic [6:0]  err_cnt;
  logic [5:0]  window_log2;

  logic        busy, done, result_valid;
  logic [40:0] word_cnt;
  logic [31:0] err_total, err_words;
  logic [6:0]  err_max;
  logic [7:0]  lock_loss;

  logic        n_busy, n_done, n_result_valid;
  logic [40:0] n_word_cnt;
  logic [7:0]  n_err_total, n_err_words;
  logic [6:0]  n_err_max;
  logic [7:0]  n_lock_loss;

  int n_tests = 0;
  int n_fail  = 0;
  logic saw;

  always #5 clk = ~clk;

  ber_monitor #(.ERR_W(7), .TOT_W(32)) dut (
    .clk(clk), .reset(reset), .aligned(aligned), .err_cnt(err_cnt),
    .start(start), .abort(abort), .window_log2(window_log2),
    .busy(busy), .done(done), .result_valid(result_valid), .word_cnt(word_cnt),
    .err_total(err_total), .err_words(err_words), .err_max(err_max), .lock_loss(lock_loss)
  );

  ber_monitor #(.ERR_W(7), .TOT_W(8)) dut_n (
    .clk(clk), .reset(reset), .aligned(aligned), .err_cnt(err_cnt),
    .start(start), .abort(abort), .window_log2(window_log2),
    .busy(n_busy), .done(n_done), .result_valid(n_result_valid), .word_cnt(n_word_cnt),
    .err_total(n_err_total), .err_words(n_err_words), .err_max(n_err_max), .lock_loss(n_lock_loss)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then take the locking cycle (aligned must already be 1).
  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic words(input int n, input logic [6:0] e);
    err_cnt = e;
    repeat (n) tick();
    err_cnt = '0;
  endtask

  initial begin
    reset = 1'b1; aligned = 1'b0; start = 1'b0; abort = 1'b0;
    err_cnt = '0; window_log2 = 6'd4;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_err_total", err_total, 0);
    chk("rst_lock_loss", lock_loss, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Clean window of 16 words
    aligned = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clean_wait_busy", busy, 1);
    tick();
    saw = 1'b0;
    repeat (15) begin tick(); if (done) saw = 1'b1; end
    chk("clean_early_done", saw, 0);
    chk("clean_wc15", word_cnt, 15);
    tick();
    chk("clean_done", done, 1);
    chk("clean_word_cnt", word_cnt, 16);
    chk("clean_err_total", err_total, 0);
    chk("clean_err_words", err_words, 0);
    chk("clean_valid", result_valid, 1);
    chk("clean_busy", busy, 0);
    tick();
    chk("clean_done_pulse", done, 0);
    chk("clean_valid_hold", result_valid, 1);
    chk("clean_wc_hold", word_cnt, 16);

    // Abort wins over start in DONE
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("prec_busy", busy, 0);
    chk("prec_valid", result_valid, 0);
    chk("prec_wc_held", word_cnt, 16);
    tick();
    chk("prec_busy2", busy, 0);

    // Error accumulation over 32 words; a start in MEASURE is ignored
    window_log2 = 6'd5;
    arm();
    chk("acc_cleared", word_cnt, 0);
    saw = 1'b0;
    for (int w = 1; w <= 32; w++) begin
      err_cnt = (w == 2 || w == 7) ? 7'd3 : (w == 20) ? 7'd5 : 7'd0;
      start = (w == 10);
      tick();
      if (w < 32 && done) saw = 1'b1;
    end
    err_cnt = '0; start = 1'b0;
    chk("acc_early_done", saw, 0);
    chk("acc_done", done, 1);
    chk("acc_word_cnt", word_cnt, 32);
    chk("acc_err_total", err_total, 11);
    chk("acc_err_words", err_words, 3);
    chk("acc_err_max", err_max, 5);
    chk("acc_lock_loss", lock_loss, 0);

    // Unlock gap of 10 cycles after 5 counted words
    window_log2 = 6'd4;
    arm();
    words(5, 0);
    aligned = 1'b0;
    repeat (10) tick();
    chk("gap_word_cnt", word_cnt, 5);
    chk("gap_lock_loss", lock_loss, 1);
`ifdef BER_MON_ABORT_ON_UNLOCK_EN
    chk("gap_busy", busy, 0);
    aligned = 1'b1;
    saw = 1'b0;
    repeat (20) begin tick(); if (done) saw = 1'b1; end
    chk("gap_no_done", saw, 0);
    chk("gap_busy_after", busy, 0);
    chk("gap_wc_held", word_cnt, 5);
`else
    chk("gap_busy", busy, 1);
    aligned = 1'b1;
    saw = 1'b0;
    repeat (10) begin tick(); if (done) saw = 1'b1; end
    chk("gap_early_done", saw, 0);
    tick();
    chk("gap_done", done, 1);
    chk("gap_word_cnt_end", word_cnt, 16);
    chk("gap_lock_loss_end", lock_loss, 1);
`endif

    // Wait for lock, then abort on the completing word
    aligned = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    chk("wl_busy", busy, 1);
    chk("wl_word_cnt", word_cnt, 0);
    chk("wl_err_total", err_total, 0);
    chk("wl_lock_loss", lock_loss, 0);
    aligned = 1'b1;
    tick();
    chk("wl_lock_cycle_wc", word_cnt, 0);
    tick();
    chk("wl_first_word", word_cnt, 1);
    words(14, 0);
    chk("ab_wc15", word_cnt, 15);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_done", done, 0);
    chk("ab_busy", busy, 0);
    chk("ab_valid", result_valid, 0);
    chk("ab_wc", word_cnt, 15);
    tick();
    chk("ab_wc_hold", word_cnt, 15);

    // window_log2 below range clamps to 16 words
    window_log2 = 6'd3;
    arm();
    saw = 1'b0;
    repeat (15) begin tick(); if (done) saw = 1'b1; end
    chk("clamp_early_done", saw, 0);
    tick();
    chk("clamp_done", done, 1);
    chk("clamp_word_cnt", word_cnt, 16);

    // Reset in MEASURE discards partial results
    window_log2 = 6'd4;
    arm();
    words(3, 2);
    chk("rm_pre_total", err_total, 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_busy", busy, 0);
    chk("rm_word_cnt", word_cnt, 0);
    chk("rm_err_total", err_total, 0);
    chk("rm_err_words", err_words, 0);
    chk("rm_err_max", err_max, 0);
    chk("rm_valid", result_valid, 0);
    chk("rm_n_word_cnt", n_word_cnt, 0);

    // Accumulator saturation on the narrow instance
    arm();
    words(2, 127);
    chk("sat_pre", n_err_total, 254);
    chk("sat_pre_words", n_err_words, 2);
    words(1, 7);
    chk("sat_total", n_err_total, 255);
    words(1, 100);
    chk("sat_hold", n_err_total, 255);
    chk("sat_wide_total", err_total, 361);
    words(12, 0);
    chk("sat_done", n_done, 1);
    chk("sat_err_max", n_err_max, 127);

    // Errored-word counter saturation over 256 words
    window_log2 = 6'd8;
    arm();
    words(256, 1);
    chk("satw_done", n_done, 1);
    chk("satw_word_cnt", n_word_cnt, 256);
    chk("satw_err_words", n_err_words, 255);
    chk("satw_err_total", n_err_total, 255);
    chk("satw_wide_words", err_words, 256);
    chk("satw_wide_total", err_total, 256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
